jtdd_gfx_rom_arb: RTL

- Shares one 16-bit graphics ROM read port between two tile-layer fetchers: client 0 is the scroll layer, client 1 is the character layer.
- Each client sees a simple address/data/ok interface. The block detects address changes, issues one read at a time to the memory port, and holds returned data per client.
- Sits between the layer modules and the SDRAM/ROM controller.

---
 rtl/jtdd_gfx_rom_arb_if.sv | 34 +++
 rtl/jtdd_gfx_rom_arb.sv | 133 +++++++++++++
 2 files changed

// File: rtl/jtdd_gfx_rom_arb_if.sv
// Bus bundle for the two-client graphics ROM arbiter: client address/data/ok
// ports plus the single memory read port.
interface jtdd_gfx_rom_arb_if #(
    parameter int unsigned AW0 = 17,
    parameter int unsigned AW1 = 15,
    parameter int unsigned MAW = 18,
    parameter int unsigned DW  = 16
);
    logic           cs0;
    logic [AW0-1:0] addr0;
    logic [DW-1:0]  data0;
    logic           ok0;

    logic           cs1;
    logic [AW1-1:0] addr1;
    logic [DW-1:0]  data1;
    logic           ok1;

    logic [MAW-1:0] mem_addr;
    logic           mem_req;
    logic [DW-1:0]  mem_data;
    logic           mem_ok;

    // master: layer fetchers and memory controller; slave: the arbiter
    modport master (
        output cs0, addr0, cs1, addr1, mem_data, mem_ok,
        input  data0, ok0, data1, ok1, mem_addr, mem_req
    );

    modport slave (
        input  cs0, addr0, cs1, addr1, mem_data, mem_ok,
        output data0, ok0, data1, ok1, mem_addr, mem_req
    );
endinterface

// File: rtl/jtdd_gfx_rom_arb.sv
// Shares one 16-bit graphics ROM read port between the scroll layer (client 0)
// and the character layer (client 1), one outstanding read at a time.
module jtdd_gfx_rom_arb #(
    parameter int unsigned AW0     = 17,
    parameter int unsigned AW1     = 15,
    parameter int unsigned MAW     = 18,
    parameter int unsigned OFFSET1 = 32'h20000,
    parameter int unsigned DW      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    jtdd_gfx_rom_arb_if.slave     bus
);
    localparam int unsigned CAW = (AW0 > AW1) ? AW0 : AW1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_mem_req;
    logic [MAW-1:0] r_mem_addr;
    logic [CAW-1:0] r_cap_addr;
    logic           r_gnt;
    logic           r_last_grant;

    logic [AW0-1:0] r_addr_l0;
    logic [AW1-1:0] r_addr_l1;
    logic           r_valid0;
    logic           r_valid1;
    logic [DW-1:0]  r_data0;
    logic [DW-1:0]  r_data1;

    logic           w_hit0;
    logic           w_hit1;
    logic           w_pend0;
    logic           w_pend1;
    logic           w_grant;
    logic           w_sel;
    logic           w_done;
    logic [MAW-1:0] w_map_addr;
    logic [CAW-1:0] w_req_addr;

    assign w_hit0  = r_valid0 & (bus.addr0 == r_addr_l0);
    assign w_hit1  = r_valid1 & (bus.addr1 == r_addr_l1);
    assign w_pend0 = bus.cs0 & ~w_hit0;
    assign w_pend1 = bus.cs1 & ~w_hit1;

    assign bus.ok0      = bus.cs0 & w_hit0;
    assign bus.ok1      = bus.cs1 & w_hit1;
    assign bus.data0    = r_data0;
    assign bus.data1    = r_data1;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_req  = r_mem_req;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend0 | w_pend1) begin
                    w_grant     = 1'b1;
                    // on a tie, the client that did not win last time goes next
                    w_sel       = (w_pend0 & w_pend1) ? ~r_last_grant : w_pend1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ok) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_map_addr = MAW'(bus.addr0);
        w_req_addr = CAW'(bus.addr0);
        if (w_sel) begin
            w_map_addr = MAW'(bus.addr1) + MAW'(OFFSET1);
            w_req_addr = CAW'(bus.addr1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_cap_addr   <= '0;
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr_l0    <= '0;
            r_addr_l1    <= '0;
            r_valid0     <= 1'b0;
            r_valid1     <= 1'b0;
            r_data0      <= '0;
            r_data1      <= '0;
        end else begin
            if (w_grant) begin
                r_mem_req    <= 1'b1;
                r_mem_addr   <= w_map_addr;
                r_cap_addr   <= w_req_addr;
                r_gnt        <= w_sel;
                r_last_grant <= w_sel;
            end
            // data is tagged with the captured address, not the live one
            if (w_done) begin
                r_mem_req <= 1'b0;
                if (r_gnt) begin
                    r_data1   <= bus.mem_data;
                    r_addr_l1 <= r_cap_addr[AW1-1:0];
                    r_valid1  <= 1'b1;
                end else begin
                    r_data0   <= bus.mem_data;
                    r_addr_l0 <= r_cap_addr[AW0-1:0];
                    r_valid0  <= 1'b1;
                end
            end
        end
    end
endmodule
